control_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It is the instruction-side counterpart of the ALU: it fetches instructions from byte memory and owns PC, IR, operand register (OPR), memory data register (MDR), accumulator (ACC) and Z flag. It drives ALU operands and operation code, consumes the ALU result and zero flag, and sequences memory reads and writes over a ready handshake.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/instr_decode.sv | 36 +++
 rtl/control_sequencer.sv | 155 +++++++++++++++
 tb/tb_control_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, ALU codes, sequencer states.
package cpu_pkg;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  // Opcode field IR[7:4]
  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_ADD = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_AND = 4'h3;
  localparam logic [3:0] OPC_OR  = 4'h4;
  localparam logic [3:0] OPC_NOT = 4'h5;
  localparam logic [3:0] OPC_SLT = 4'h6;
  localparam logic [3:0] OPC_LDA = 4'h7;
  localparam logic [3:0] OPC_STA = 4'h8;
  localparam logic [3:0] OPC_LDI = 4'h9;
  localparam logic [3:0] OPC_JMP = 4'hA;
  localparam logic [3:0] OPC_JZ  = 4'hB;
  localparam logic [3:0] OPC_HLT = 4'hF;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_OPND, ST_MEMRD, ST_EXEC, ST_MEMWR, ST_HALT
  } state_e;

  // Instruction class: selects the path through the sequencer
  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_NOT, CLS_LDA, CLS_STA, CLS_LDI, CLS_JMP, CLS_JZ, CLS_HLT
  } iclass_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode: ALU code, instruction class, length, illegal.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opc_i,
  output logic [2:0] alu_op_o,
  output iclass_e    cls_o,
  output logic       two_byte_o,
  output logic       illegal_o
);

  // Undefined opcodes decode as NOP with the illegal flag raised
  always_comb begin
    alu_op_o   = ALU_ADD;
    cls_o      = CLS_NOP;
    two_byte_o = 1'b0;
    illegal_o  = 1'b0;
    case (opc_i)
      OPC_NOP: ;
      OPC_ADD: begin alu_op_o = ALU_ADD; cls_o = CLS_ALU; two_byte_o = 1'b1; end
      OPC_SUB: begin alu_op_o = ALU_SUB; cls_o = CLS_ALU; two_byte_o = 1'b1; end
      OPC_AND: begin alu_op_o = ALU_AND; cls_o = CLS_ALU; two_byte_o = 1'b1; end
      OPC_OR:  begin alu_op_o = ALU_OR;  cls_o = CLS_ALU; two_byte_o = 1'b1; end
      OPC_SLT: begin alu_op_o = ALU_SLT; cls_o = CLS_ALU; two_byte_o = 1'b1; end
      OPC_NOT: begin alu_op_o = ALU_NOT; cls_o = CLS_NOT; end
      OPC_LDA: begin cls_o = CLS_LDA; two_byte_o = 1'b1; end
      OPC_STA: begin cls_o = CLS_STA; two_byte_o = 1'b1; end
      OPC_LDI: begin cls_o = CLS_LDI; two_byte_o = 1'b1; end
      OPC_JMP: begin cls_o = CLS_JMP; two_byte_o = 1'b1; end
      OPC_JZ:  begin cls_o = CLS_JZ;  two_byte_o = 1'b1; end
      OPC_HLT: cls_o = CLS_HLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR, OPR, MDR, ACC, Z.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic [7:0] pc,
  output logic [7:0] acc,
  output logic       zflag,
  output logic       halted,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d, ir_q, ir_d, opr_q, opr_d, mdr_q, mdr_d, acc_q, acc_d;
  logic       z_q, z_d, ill_q, ill_d;

  iclass_e    dec_cls;
  logic       dec_two, dec_ill;
  logic [2:0] dec_alu_op;

  // Low opcode nibble is don't-care in the instruction format
  logic       unused_ir_bits;
  assign unused_ir_bits = ^ir_q[3:0];

  instr_decode u_dec (
    .opc_i      (ir_q[7:4]),
    .alu_op_o   (dec_alu_op),
    .cls_o      (dec_cls),
    .two_byte_o (dec_two),
    .illegal_o  (dec_ill)
  );

  // State and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      opr_q   <= '0;
      mdr_q   <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      mdr_q   <= mdr_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state and Moore memory outputs; registers only move on the ready cycle
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opr_d    = opr_q;
    mdr_d    = mdr_q;
    acc_d    = acc_q;
    z_d      = z_q;
    ill_d    = ill_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = 8'h00;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_ill) ill_d = 1'b1;
        if (dec_cls == CLS_HLT)      state_d = ST_HALT;
        else if (dec_cls == CLS_NOT) state_d = ST_EXEC;
        else if (dec_two)            state_d = ST_OPND;
        else                         state_d = ST_FETCH;
      end
      ST_OPND: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          opr_d = mem_rdata;
          pc_d  = pc_q + 8'd1;
          case (dec_cls)
            CLS_JMP: begin pc_d = mem_rdata; state_d = ST_FETCH; end
            CLS_JZ: begin
              if (z_q) pc_d = mem_rdata;
              state_d = ST_FETCH;
            end
            CLS_LDI: state_d = ST_EXEC;
            CLS_STA: state_d = ST_MEMWR;
            default: state_d = ST_MEMRD;
          endcase
        end
      end
      ST_MEMRD: begin
        mem_rd   = 1'b1;
        mem_addr = opr_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_LDA: begin acc_d = mdr_q; z_d = (mdr_q == 8'h00); end
          CLS_LDI: begin acc_d = opr_q; z_d = (opr_q == 8'h00); end
          default: begin acc_d = alu_result; z_d = alu_zero; end
        endcase
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_wr   = 1'b1;
        mem_addr = opr_q;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = mdr_q;
  assign alu_op    = dec_alu_op;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign zflag     = z_q;
  assign halted    = (state_q == ST_HALT);
  assign illegal   = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: ISA-level reference model predicts bus transactions,
// final state and zero-wait cycle count; a monitor checks the bus.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd, mem_wr, mem_ready, alu_zero, zflag, halted, illegal;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, pc, acc;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  control_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .pc(pc), .acc(acc), .zflag(zflag), .halted(halted),
    .illegal(illegal)
  );

  // ALU stand-in driven by the ALU code
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_a;
      3'b101:  alu_result = (alu_a < alu_b) ? 8'd1 : 8'd0;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } txn_t;
  txn_t       exp_q[$];
  logic [7:0] img [256];
  logic [7:0] mem [256];
  int         checks = 0, errors = 0;
  int         wait_mode = 0, stall = 0;
  int         wait_cnt = 0, wr_cycles = 0, wr_txn = 0;
  logic [7:0] e_acc, e_pc;
  logic       e_z, e_ill;
  int         e_lat;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  function automatic bit is_two(input logic [3:0] op);
    return (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB});
  endfunction

  // Instruction-level interpreter over a private copy of the image
  function automatic void model_run();
    logic [7:0] m [256];
    logic [7:0] p, a, o, b;
    logic [3:0] op;
    logic z, il;
    int lat;
    bit done;
    m = img; p = 8'h00; a = 8'h00; z = 1'b0; il = 1'b0; lat = 0; done = 0;
    for (int step = 0; step < 500 && !done; step++) begin
      exp_q.push_back('{1'b0, p, 8'h00});
      op = m[p][7:4]; p = p + 8'd1;
      if (!is_two(op)) begin
        case (op)
          4'h5: begin a = ~a; z = (a == 8'h00); lat += 3; end
          4'hF: begin lat += 2; done = 1; end
          4'hC, 4'hD, 4'hE: begin il = 1'b1; lat += 2; end
          default: lat += 2;
        endcase
      end else begin
        exp_q.push_back('{1'b0, p, 8'h00});
        o = m[p]; p = p + 8'd1;
        case (op)
          4'hA: begin p = o; lat += 3; end
          4'hB: begin if (z) p = o; lat += 3; end
          4'h9: begin a = o; z = (a == 8'h00); lat += 4; end
          4'h8: begin exp_q.push_back('{1'b1, o, a}); m[o] = a; lat += 4; end
          default: begin
            exp_q.push_back('{1'b0, o, 8'h00});
            b = m[o];
            case (op)
              4'h1: a = a + b;
              4'h2: a = a - b;
              4'h3: a = a & b;
              4'h4: a = a | b;
              4'h6: a = (a < b) ? 8'd1 : 8'd0;
              default: a = b;  // LDA
            endcase
            z = (a == 8'h00); lat += 5;
          end
        endcase
      end
    end
    e_acc = a; e_pc = p; e_z = z; e_ill = il; e_lat = lat;
  endfunction

  // Memory responder: random or fixed wait states, ready noise when idle
  initial begin
    int waited, target;
    mem_ready = 1'b0; mem_rdata = 8'h00; waited = 0; target = 0;
    forever begin
      @(posedge clk); #2;
      if (rst || stall != 0) begin
        mem_ready = 1'b0; waited = 0;
        target = (wait_mode < 0) ? $urandom_range(0, 2) : wait_mode;
      end else if (mem_rd || mem_wr) begin
        if (waited >= target) begin
          mem_ready = 1'b1;
          mem_rdata = mem_rd ? mem[mem_addr] : 8'($urandom);
          waited = 0;
          target = (wait_mode < 0) ? $urandom_range(0, 2) : wait_mode;
        end else begin
          mem_ready = 1'b0; mem_rdata = 8'($urandom); waited++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
      end
    end
  end

  // Bus monitor: pops expected transactions on each accepted request
  logic       prev_wait = 1'b0;
  logic [9:0] prev_req;
  always @(negedge clk) begin
    txn_t e;
    if (rst) prev_wait = 1'b0;
    else if (mem_rd || mem_wr) begin
      chk("rd_wr_exclusive", int'(mem_rd && mem_wr), 0);
      if (prev_wait) chk("req_stable", int'({mem_rd, mem_wr, mem_addr}), int'(prev_req));
      if (mem_wr) wr_cycles++;
      if (mem_ready) begin
        prev_wait = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: wr=%0d addr %0h", mem_wr, mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("txn_kind_wr", int'(mem_wr), int'(e.wr));
          chk("txn_addr", int'(mem_addr), int'(e.addr));
          if (e.wr) chk("txn_wdata", int'(mem_wdata), int'(e.data));
        end
        if (mem_wr) begin mem[mem_addr] = mem_wdata; wr_txn++; end
      end else begin
        wait_cnt++; prev_wait = 1'b1; prev_req = {mem_rd, mem_wr, mem_addr};
      end
    end else prev_wait = 1'b0;
  end

  task automatic start_prog(input int wmode);
    rst = 1'b1;
    exp_q.delete();
    model_run();
    mem = img;
    wait_mode = wmode; stall = 0;
    wait_cnt = 0; wr_cycles = 0; wr_txn = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_prog(input string nm, input int wmode);
    int cyc;
    bit done;
    start_prog(wmode);
    cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (halted) done = 1;
      else begin
        cyc++;
        if (cyc > 3000) begin
          checks++; errors++;
          $display("FAIL %s timeout: got no halt want halt", nm);
          done = 1;
        end
      end
    end
    chk({nm, "_cycles"}, cyc, 1 + e_lat + wait_cnt);
    chk({nm, "_acc"}, int'(acc), int'(e_acc));
    chk({nm, "_z"}, int'(zflag), int'(e_z));
    chk({nm, "_pc"}, int'(pc), int'(e_pc));
    chk({nm, "_illegal"}, int'(illegal), int'(e_ill));
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_halt_idle"}, int'(mem_rd | mem_wr), 0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic gen_random();
    logic [3:0] ops[$];
    int adr[$];
    int n, a, j;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    n = $urandom_range(8, 25);
    for (int i = 0; i < n; i++) ops.push_back(4'($urandom_range(0, 14)));
    ops.push_back(4'hF);
    a = 0;
    for (int i = 0; i <= n; i++) begin adr.push_back(a); a += is_two(ops[i]) ? 2 : 1; end
    for (int i = 0; i <= n; i++) begin
      img[adr[i]] = {ops[i], 4'($urandom)};
      if (is_two(ops[i])) begin
        if (ops[i] == 4'hA || ops[i] == 4'hB) begin
          j = $urandom_range(i + 1, n);
          img[adr[i] + 1] = 8'(adr[j]);
        end else if (ops[i] == 4'h9)
          img[adr[i] + 1] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        else
          img[adr[i] + 1] = 8'($urandom_range(128, 255));
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    #1;
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_wr", int'(mem_wr), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_z", int'(zflag), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_illegal", int'(illegal), 0);

    clear_img(); img[0] = 8'h90; img[1] = 8'h05; img[2] = 8'hF0;
    run_prog("ldi_hlt", 0);
    chk("ldi_hlt_abs_cycles", 1 + e_lat, 7);

    clear_img();
    img[0] = 8'h90; img[1] = 8'h03; img[2] = 8'h10; img[3] = 8'h20; img[4] = 8'hF0;
    img[8'h20] = 8'hFD;
    run_prog("add_zero", 0);
    chk("add_zero_abs_acc", int'(acc), 0);
    chk("add_zero_abs_z", int'(zflag), 1);

    clear_img();
    img[0] = 8'h90; img[1] = 8'h07; img[2] = 8'h80; img[3] = 8'h30; img[4] = 8'hF0;
    run_prog("sta_wait", 3);
    chk("sta_wr_cycles", wr_cycles, 4);
    chk("sta_wr_once", wr_txn, 1);
    chk("sta_mem", int'(mem[8'h30]), 7);

    clear_img();
    img[0] = 8'h90; img[1] = 8'h00; img[2] = 8'hB0; img[3] = 8'h40; img[4] = 8'hF0;
    img[8'h40] = 8'hF0;
    run_prog("jz_taken", -1);
    img[1] = 8'h01;
    run_prog("jz_not_taken", -1);

    clear_img();
    img[0] = 8'hC0; img[1] = 8'h90; img[2] = 8'h01; img[3] = 8'hF0;
    run_prog("illegal_op", 0);

    clear_img();
    img[0] = 8'hA0; img[1] = 8'hFF; img[8'hFF] = 8'h90;
    run_prog("pc_wrap", -1);

    // Reset while the FETCH after LDI 5 is stalled
    clear_img(); img[0] = 8'h90; img[1] = 8'h05; img[2] = 8'hF0;
    start_prog(0);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(pc == 8'h02 && !mem_rd) && guard < 50);
    chk("rst_mid_reach", int'(guard < 50), 1);
    stall = 1;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre_rd", int'(mem_rd), 1);
    chk("rst_mid_pre_addr", int'(mem_addr), 2);
    chk("rst_mid_pre_acc", int'(acc), 5);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_rd_drop", int'(mem_rd), 0);
    chk("rst_mid_addr", int'(mem_addr), 0);
    chk("rst_mid_pc", int'(pc), 0);
    chk("rst_mid_acc", int'(acc), 0);
    exp_q.delete(); model_run(); stall = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_boot_idle", int'(mem_rd), 0);
    @(negedge clk);
    chk("rst_mid_fetch_rd", int'(mem_rd), 1);
    chk("rst_mid_fetch_addr", int'(mem_addr), 0);

    for (int t = 0; t < 40; t++) begin
      gen_random();
      run_prog("random", -1);
    end

    rst = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
